// File: rtl/riscv_decode_issue.sv
// Decode/issue stage for the RV32I lab core.
// Decodes the instruction word and holds the result in a decode/execute
// register with a valid/ready handshake. A writeback scoreboard detects
// RAW hazards and either stalls issue or selects forwarding sources.
module riscv_decode_issue #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned WB_LAT    = 2,
    parameter bit          FORWARD   = 1'b1,
    parameter int unsigned NUM_IO    = 2,
    parameter logic [11:0] IO_IN_CSR = 12'hF00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic [3:0]        ex_aluop,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic [1:0]        ex_regsel,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [NUM_IO-1:0] ex_gpio_we,
    output logic [1:0]        ex_fwd_rs1,
    output logic [1:0]        ex_fwd_rs2,
    output logic              ex_illegal
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    typedef struct packed {
        logic              illegal;
        logic [3:0]        aluop;
        logic              alusrc;
        logic              regwrite;
        logic [1:0]        regsel;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [XLEN-1:0]   imm;
        logic [NUM_IO-1:0] gpio_we;
        logic [1:0]        fwd_rs1;
        logic [1:0]        fwd_rs2;
    } ex_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign csr    = instr[31:20];

    ex_t  dec;
    ex_t  ex_q;
    logic ex_valid_q;
    logic alive_q;
    logic use_rs1;
    logic use_rs2;
    logic csr_hit;

    logic [WB_LAT-1:0]      sb_valid_q;
    logic [WB_LAT-1:0][4:0] sb_rd_q;

    logic       hit_rs1;
    logic       hit_rs2;
    logic [1:0] fwd_rs1;
    logic [1:0] fwd_rs2;
    logic       stall;
    logic       accept;

    // Instruction decode into control fields and rs-used flags.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        csr_hit = 1'b0;
        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        case (opcode)
            OP_R: begin
                dec.regwrite = 1'b1;
                dec.regsel   = 2'b10;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                case (funct7)
                    7'b0000000: dec.aluop = {1'b0, funct3};
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec.aluop = 4'b1000;
                        else if (funct3 == 3'b101) dec.aluop = 4'b1101;
                        else                       dec.illegal = 1'b1;
                    end
                    7'b0000001: begin
                        case (funct3)
                            3'b000:  dec.aluop = 4'b1001;
                            3'b001:  dec.aluop = 4'b1010;
                            3'b011:  dec.aluop = 4'b1011;
                            default: dec.illegal = 1'b1;
                        endcase
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_I: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.regsel   = 2'b10;
                dec.imm      = XLEN'(signed'(instr[31:20]));
                use_rs1      = 1'b1;
                case (funct3)
                    3'b001: begin
                        if (funct7 == 7'b0000000) dec.aluop = 4'b0001;
                        else                      dec.illegal = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec.aluop = 4'b0101;
                        else if (funct7 == 7'b0100000) dec.aluop = 4'b1101;
                        else                           dec.illegal = 1'b1;
                    end
                    default: dec.aluop = {1'b0, funct3};
                endcase
            end
            OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.regsel   = 2'b01;
                dec.imm      = XLEN'(signed'({instr[31:12], 12'b0}));
            end
            OP_SYS: begin
                if (funct3 == 3'b001) begin
                    use_rs1 = 1'b1;
                    if (csr == IO_IN_CSR) begin
                        dec.regwrite = 1'b1;
                        csr_hit      = 1'b1;
                    end
                    for (int k = 0; k < int'(NUM_IO); k++) begin
                        if (csr == 12'hF02 + 12'(2 * k)) begin
                            dec.gpio_we[k] = 1'b1;
                            dec.regwrite   = 1'b1;
                            csr_hit        = 1'b1;
                        end
                    end
                    if (!csr_hit) dec.illegal = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal encodings issue with no side effects and no operand use.
        if (dec.illegal) begin
            dec.aluop    = '0;
            dec.alusrc   = 1'b0;
            dec.regwrite = 1'b0;
            dec.regsel   = '0;
            dec.imm      = '0;
            dec.gpio_we  = '0;
            use_rs1      = 1'b0;
            use_rs2      = 1'b0;
        end
        if (dec.rd == 5'd0) dec.regwrite = 1'b0;
    end

    // RAW hazard lookup; scanning oldest to youngest lets the youngest match win.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        fwd_rs1 = 2'b00;
        fwd_rs2 = 2'b00;
        for (int i = int'(WB_LAT) - 1; i >= 0; i--) begin
            if (use_rs1 && dec.rs1 != 5'd0 && sb_valid_q[i] && sb_rd_q[i] == dec.rs1) begin
                hit_rs1 = 1'b1;
                fwd_rs1 = 2'(i + 1);
            end
            if (use_rs2 && dec.rs2 != 5'd0 && sb_valid_q[i] && sb_rd_q[i] == dec.rs2) begin
                hit_rs2 = 1'b1;
                fwd_rs2 = 2'(i + 1);
            end
        end
        if (!FORWARD) begin
            fwd_rs1 = 2'b00;
            fwd_rs2 = 2'b00;
        end
    end

    assign stall       = !FORWARD && (hit_rs1 || hit_rs2);
    assign instr_ready = alive_q && ex_ready && !flush && !stall;
    assign accept      = instr_valid && instr_ready;

    // Decode/execute register and scoreboard shift; flush beats issue and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of its neighbours.
        if (!rst_n) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            alive_q    <= 1'b0;
            sb_valid_q <= '0;
            sb_rd_q    <= '0;
        end else begin
            alive_q <= 1'b1;
            if (flush) begin
                ex_q       <= '0;
                ex_valid_q <= 1'b0;
                sb_valid_q <= '0;
            end else if (ex_ready) begin
                ex_valid_q <= accept;
                if (accept) begin
                    ex_q         <= dec;
                    ex_q.fwd_rs1 <= fwd_rs1;
                    ex_q.fwd_rs2 <= fwd_rs2;
                end else begin
                    ex_q <= '0;
                end
                for (int i = int'(WB_LAT) - 1; i > 0; i--) begin
                    sb_valid_q[i] <= sb_valid_q[i-1];
                    sb_rd_q[i]    <= sb_rd_q[i-1];
                end
                sb_valid_q[0] <= accept && dec.regwrite;
                sb_rd_q[0]    <= dec.rd;
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_aluop    = ex_q.aluop;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_regsel   = ex_q.regsel;
    assign ex_rd       = ex_q.rd;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_imm      = ex_q.imm;
    assign ex_gpio_we  = ex_q.gpio_we;
    assign ex_fwd_rs1  = ex_q.fwd_rs1;
    assign ex_fwd_rs2  = ex_q.fwd_rs2;
    assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_riscv_decode_issue.sv
// Directed bench for riscv_decode_issue: one forwarding instance and one
// stalling instance, both WB_LAT=2, NUM_IO=2.
module tb_riscv_decode_issue;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Forwarding instance signals
    logic        instr_valid, instr_ready, ex_ready, flush;
    logic [31:0] instr;
    logic        ex_valid, ex_alusrc, ex_regwrite, ex_illegal;
    logic [3:0]  ex_aluop;
    logic [1:0]  ex_regsel, ex_gpio_we, ex_fwd_rs1, ex_fwd_rs2;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [31:0] ex_imm;

    // Stalling instance signals
    logic        s_instr_valid, s_instr_ready, s_ex_ready, s_flush;
    logic [31:0] s_instr;
    logic        s_ex_valid, s_ex_alusrc, s_ex_regwrite, s_ex_illegal;
    logic [3:0]  s_ex_aluop;
    logic [1:0]  s_ex_regsel, s_ex_gpio_we, s_ex_fwd_rs1, s_ex_fwd_rs2;
    logic [4:0]  s_ex_rd, s_ex_rs1, s_ex_rs2;
    logic [31:0] s_ex_imm;

    riscv_decode_issue #(.XLEN(32), .WB_LAT(2), .FORWARD(1'b1), .NUM_IO(2), .IO_IN_CSR(12'hF00)) u_fwd (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_regsel(ex_regsel), .ex_rd(ex_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_gpio_we(ex_gpio_we),
        .ex_fwd_rs1(ex_fwd_rs1), .ex_fwd_rs2(ex_fwd_rs2), .ex_illegal(ex_illegal)
    );

    riscv_decode_issue #(.XLEN(32), .WB_LAT(2), .FORWARD(1'b0), .NUM_IO(2), .IO_IN_CSR(12'hF00)) u_stall (
        .clk(clk), .rst_n(rst_n), .instr_valid(s_instr_valid), .instr(s_instr),
        .instr_ready(s_instr_ready), .ex_ready(s_ex_ready), .flush(s_flush),
        .ex_valid(s_ex_valid), .ex_aluop(s_ex_aluop), .ex_alusrc(s_ex_alusrc),
        .ex_regwrite(s_ex_regwrite), .ex_regsel(s_ex_regsel), .ex_rd(s_ex_rd),
        .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_imm(s_ex_imm), .ex_gpio_we(s_ex_gpio_we),
        .ex_fwd_rs1(s_ex_fwd_rs1), .ex_fwd_rs2(s_ex_fwd_rs2), .ex_illegal(s_ex_illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to the forwarding instance for one edge.
    task automatic issue(input logic [31:0] w);
        instr_valid = 1'b1;
        instr       = w;
        tick();
        instr_valid = 1'b0;
        instr       = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instr = '0; ex_ready = 1'b1; flush = 1'b0;
        s_instr_valid = 1'b0; s_instr = '0; s_ex_ready = 1'b1; s_flush = 1'b0;

        // Reset state
        #12;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_imm", ex_imm, 0);
        check("rst_ready", instr_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", instr_ready, 0);
        tick();
        check("rel_ready_after_edge", instr_ready, 1);

        // Stall mode: ADDI x5,x0,7 then ADD x6,x5,x5
        s_instr_valid = 1'b1; s_instr = 32'h00700293;
        tick();
        check("s_addi_valid", s_ex_valid, 1);
        check("s_addi_imm", s_ex_imm, 32'd7);
        s_instr = 32'h00528333;
        #1;
        check("s_stall_c1", s_instr_ready, 0);
        tick();
        check("s_stall_c2", s_instr_ready, 0);
        check("s_bubble_valid", s_ex_valid, 0);
        tick();
        check("s_ready_c3", s_instr_ready, 1);
        tick();
        s_instr_valid = 1'b0;
        check("s_add_valid", s_ex_valid, 1);
        check("s_add_rd", s_ex_rd, 6);
        check("s_add_imm", s_ex_imm, 0);
        check("s_add_fwd", {s_ex_fwd_rs1, s_ex_fwd_rs2}, 4'b0000);

        // ADD x3,x1,x2
        issue(32'h002081B3);
        check("add_valid", ex_valid, 1);
        check("add_aluop", ex_aluop, 4'b0000);
        check("add_alusrc", ex_alusrc, 0);
        check("add_regsel", ex_regsel, 2'b10);
        check("add_regwrite", ex_regwrite, 1);
        check("add_rd_rs", {ex_rd, ex_rs1, ex_rs2}, {5'd3, 5'd1, 5'd2});
        check("add_fwd", {ex_fwd_rs1, ex_fwd_rs2}, 4'b0000);
        tick();
        check("bubble_valid", ex_valid, 0);
        check("bubble_regwrite", ex_regwrite, 0);
        tick();

        // Forward mode: ADDI x5,x0,7 back-to-back with ADD x6,x5,x5
        instr_valid = 1'b1; instr = 32'h00700293;
        tick();
        check("addi_imm", ex_imm, 32'd7);
        check("addi_alusrc", ex_alusrc, 1);
        instr = 32'h00528333;
        #1;
        check("fwd_no_stall", instr_ready, 1);
        tick();
        check("fwd_add_rd", ex_rd, 6);
        check("fwd_add_imm", ex_imm, 0);
        check("fwd_add_fwd", {ex_fwd_rs1, ex_fwd_rs2}, 4'b0101);
        // SRAI x7,x5,3: x5 now sits in slot 1
        instr = 32'h4032D393;
        tick();
        instr_valid = 1'b0;
        check("srai_aluop", ex_aluop, 4'b1101);
        check("srai_imm", ex_imm, 32'h403);
        check("srai_fwd", {ex_fwd_rs1, ex_fwd_rs2}, 4'b1000);
        tick();
        tick();

        // GPIO CSRs and decode variety
        issue(32'hF0439073);
        check("gpio1_we", ex_gpio_we, 2'b10);
        check("gpio1_regwrite", ex_regwrite, 0);
        check("gpio1_illegal", ex_illegal, 0);
        issue(32'hF0839073);
        check("csr_bad_illegal", ex_illegal, 1);
        check("csr_bad_we", ex_gpio_we, 2'b00);
        check("csr_bad_regwrite", ex_regwrite, 0);
        issue(32'hF00014F3);
        check("gpio_in_regwrite", ex_regwrite, 1);
        check("gpio_in_regsel", ex_regsel, 2'b00);
        check("gpio_in_rd", ex_rd, 9);
        issue(32'h403100B3);
        check("sub_aluop", ex_aluop, 4'b1000);
        issue(32'h02418133);
        check("mul_aluop", ex_aluop, 4'b1001);
        issue(32'hFFF00093);
        check("addi_neg_imm", ex_imm, 32'hFFFFFFFF);
        issue(32'h00000000);
        check("opcode_illegal", ex_illegal, 1);
        check("opcode_ill_regwrite", ex_regwrite, 0);
        tick();
        tick();

        // Hold with LUI x4,0x12345 pending, then flush during the hold
        issue(32'h12345237);
        check("lui_imm", ex_imm, 32'h12345000);
        check("lui_regsel", ex_regsel, 2'b01);
        ex_ready = 1'b0;
        instr_valid = 1'b1; instr = 32'h002081B3;
        #1;
        check("hold_ready", instr_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold_valid", ex_valid, 1);
            check("hold_imm", ex_imm, 32'h12345000);
            check("hold_rd", ex_rd, 4);
        end
        flush = 1'b1;
        instr = 32'h004202B3;
        #1;
        check("flush_ready", instr_ready, 0);
        tick();
        check("flush_valid", ex_valid, 0);
        check("flush_imm", ex_imm, 0);
        flush = 1'b0; ex_ready = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("post_flush_rd", ex_rd, 5);
        check("post_flush_fwd", {ex_fwd_rs1, ex_fwd_rs2}, 4'b0000);

        // Asynchronous reset mid-stream
        issue(32'hF0239073);
        check("gpio0_we", ex_gpio_we, 2'b01);
        check("gpio0_valid", ex_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", ex_valid, 0);
        check("async_rst_we", ex_gpio_we, 2'b00);
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        check("rst2_ready_before_edge", instr_ready, 0);
        tick();
        check("rst2_ready_after_edge", instr_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
